// File: rtl/rv32_bus_arbiter.sv
// rv32_bus_arbiter: round-robin N-master to 1-slave memory arbiter with one
// outstanding transaction and a watchdog that completes stalled accesses with an error.
module rv32_bus_arbiter #(
   parameter int NUM_MASTERS = 2,
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32,
   parameter int TIMEOUT = 255,
   parameter logic [DATA_W-1:0] ERR_DATA = '0,
   localparam int OW = NUM_MASTERS > 1 ? $clog2(NUM_MASTERS) : 1,
   localparam int MW = DATA_W / 8,
   localparam int CW = TIMEOUT > 0 ? $clog2(TIMEOUT + 1) : 1
) (
   input  logic                          clk_i,
   input  logic                          rst_n_i,
   input  logic [NUM_MASTERS-1:0]        m_req_i,
   input  logic [NUM_MASTERS-1:0]        m_we_i,
   input  logic [NUM_MASTERS*ADDR_W-1:0] m_addr_i,
   input  logic [NUM_MASTERS*DATA_W-1:0] m_wdata_i,
   input  logic [NUM_MASTERS*MW-1:0]     m_wmask_i,
   output logic [NUM_MASTERS-1:0]        m_gnt_o,
   output logic [NUM_MASTERS-1:0]        m_rvalid_o,
   output logic [DATA_W-1:0]             m_rdata_o,
   output logic                          m_err_o,
   output logic                          s_req_o,
   output logic                          s_we_o,
   output logic [ADDR_W-1:0]             s_addr_o,
   output logic [DATA_W-1:0]             s_wdata_o,
   output logic [MW-1:0]                 s_wmask_o,
   input  logic                          s_gnt_i,
   input  logic                          s_rvalid_i,
   input  logic [DATA_W-1:0]             s_rdata_i,
   output logic                          busy_o,
   output logic [OW-1:0]                 owner_o
);
   typedef enum logic [1:0] {IDLE, SREQ, SRSP} state_t;
   state_t state;
   logic [OW-1:0] ptr, win;
   logic [OW:0] idx;
   logic [CW-1:0] cnt;
   logic tmo, any;
   assign any = |m_req_i;
   assign m_gnt_o = (state == IDLE && any) ? NUM_MASTERS'(1) << win : '0;
   assign s_req_o = state == SREQ;
   assign busy_o = state != IDLE;
   assign tmo = TIMEOUT != 0 && cnt == CW'(TIMEOUT - 1);
   // Scan downward so the last hit is the first requester at or above ptr.
   always_comb begin
      win = '0;
      idx = '0;
      for (int i = NUM_MASTERS - 1; i >= 0; i--) begin
         idx = {1'b0, ptr} + (OW+1)'(i);
         if (idx >= (OW+1)'(NUM_MASTERS)) idx = idx - (OW+1)'(NUM_MASTERS);
         if (m_req_i[idx[OW-1:0]]) win = idx[OW-1:0];
      end
   end
   always_ff @(posedge clk_i or negedge rst_n_i)
      if (!rst_n_i) begin
         state <= IDLE;
         ptr <= '0;
         cnt <= '0;
         owner_o <= '0;
         m_rvalid_o <= '0;
         m_rdata_o <= '0;
         m_err_o <= 1'b0;
         s_we_o <= 1'b0;
         s_addr_o <= '0;
         s_wdata_o <= '0;
         s_wmask_o <= '0;
      end else begin
         m_rvalid_o <= '0;
         m_err_o <= 1'b0;
         case (state)
            IDLE: if (any) begin
               s_we_o <= m_we_i[win];
               s_addr_o <= m_addr_i[win*ADDR_W +: ADDR_W];
               s_wdata_o <= m_wdata_i[win*DATA_W +: DATA_W];
               s_wmask_o <= m_wmask_i[win*MW +: MW];
               owner_o <= win;
               ptr <= (win == OW'(NUM_MASTERS - 1)) ? '0 : win + OW'(1);
               cnt <= '0;
               state <= SREQ;
            end
            default: begin
               cnt <= cnt + CW'(1);
               // A response in SREQ is not taken; it is expected in SRSP.
               if (state == SRSP && s_rvalid_i) begin
                  m_rvalid_o <= NUM_MASTERS'(1) << owner_o;
                  m_rdata_o <= s_rdata_i;
                  state <= IDLE;
               end else if (tmo) begin
                  m_rvalid_o <= NUM_MASTERS'(1) << owner_o;
                  m_rdata_o <= ERR_DATA;
                  m_err_o <= 1'b1;
                  state <= IDLE;
               end else if (state == SREQ && s_gnt_i) state <= SRSP;
            end
         endcase
      end
endmodule
